// File: rtl/ula_control_mc.sv
// Registered ALU-control unit: decodes alu_cmd + funct3/funct7 into an ALU op code and
// sequences single-cycle and multi-cycle (mul/div) ops over valid/ready handshakes.
module ula_control_mc #(
  parameter int unsigned OP_W       = 4,
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [3:0]      alu_cmd,
  input  logic [31:0]     instruction,
  output logic [OP_W-1:0] alu_op,
  output logic            op_valid,
  input  logic            op_ready,
  output logic            md_busy,
  output logic            illegal
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpSlt  = 4'd8;
  localparam logic [3:0] OpSltu = 4'd9;
  localparam logic [3:0] OpMul  = 4'd10;
  localparam logic [3:0] OpMulh = 4'd11;
  localparam logic [3:0] OpDiv  = 4'd12;
  localparam logic [3:0] OpRem  = 4'd13;
  localparam logic [3:0] OpIll  = 4'd15;

  typedef enum logic [1:0] {StIdle, StMulti, StHold} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              op_valid_q, op_valid_d;
  logic              md_busy_q, md_busy_d;
  logic              illegal_q, illegal_d;

  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [3:0] dec_op;
  logic       dec_md, dec_div, dec_ill;
  logic       accept;
  logic       unused_instr;

  assign funct7       = instruction[31:25];
  assign funct3       = instruction[14:12];
  assign unused_instr = ^{instruction[24:15], instruction[11:0]};

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    unique case (f3)
      3'b000:  base_op = OpAdd;
      3'b001:  base_op = OpSll;
      3'b010:  base_op = OpSlt;
      3'b011:  base_op = OpSltu;
      3'b100:  base_op = OpXor;
      3'b101:  base_op = OpSrl;
      3'b110:  base_op = OpOr;
      default: base_op = OpAnd;
    endcase
  endfunction

  always_comb begin
    dec_op  = OpAdd;
    dec_md  = 1'b0;
    dec_div = 1'b0;
    dec_ill = 1'b0;
    unique case (alu_cmd)
      4'b0000: begin
        if (funct7 == 7'b0000000) begin
          dec_op = base_op(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec_op = OpSub;
          else if (funct3 == 3'b101) dec_op = OpSra;
          else                       dec_ill = 1'b1;
        end else if (funct7 == 7'b0000001 && ENABLE_M) begin
          dec_md = 1'b1;
          unique case (funct3)
            3'b000:                 dec_op = OpMul;
            3'b001, 3'b010, 3'b011: dec_op = OpMulh;
            3'b100, 3'b101: begin
              dec_op  = OpDiv;
              dec_div = 1'b1;
            end
            default: begin
              dec_op  = OpRem;
              dec_div = 1'b1;
            end
          endcase
        end else begin
          dec_ill = 1'b1;
        end
      end
      4'b0001: dec_op = OpAdd;
      4'b0010: dec_op = OpSub;
      4'b0011: dec_op = OpAnd;
      // I-type never yields sub; bit 30 only selects arithmetic right shift
      4'b0100: dec_op = (funct3 == 3'b101 && instruction[30]) ? OpSra : base_op(funct3);
      default: dec_op = OpAdd;
    endcase
    if (dec_ill) dec_op = OpIll;
  end

  assign ready_out = (state_q == StIdle) || ((state_q == StHold) && op_ready);
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_op_d   = alu_op_q;
    op_valid_d = op_valid_q;
    md_busy_d  = md_busy_q;
    illegal_d  = illegal_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (state_q == StHold && op_ready) begin
          state_d    = StIdle;
          op_valid_d = 1'b0;
        end
        if (accept) begin
          alu_op_d  = OP_W'(dec_op);
          illegal_d = dec_ill;
          if (dec_md) begin
            state_d    = StMulti;
            cnt_d      = dec_div ? CntW'(DIV_CYCLES - 1) : CntW'(MUL_CYCLES - 1);
            md_busy_d  = 1'b1;
            op_valid_d = 1'b0;
          end else begin
            state_d    = StHold;
            op_valid_d = 1'b1;
          end
        end
      end
      StMulti: begin
        if (cnt_q == '0) begin
          state_d    = StHold;
          md_busy_d  = 1'b0;
          op_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      alu_op_q   <= '0;
      op_valid_q <= 1'b0;
      md_busy_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_op_q   <= alu_op_d;
      op_valid_q <= op_valid_d;
      md_busy_q  <= md_busy_d;
      illegal_q  <= illegal_d;
    end
  end

  assign alu_op   = alu_op_q;
  assign op_valid = op_valid_q;
  assign md_busy  = md_busy_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_ula_control_mc.sv
// Scoreboard bench for ula_control_mc: expected ops queued at accept, compared at consume.
module tb_ula_control_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        op_ready = 1'b1;
  logic        valid_nm = 1'b0;
  logic [3:0]  alu_cmd = '0;
  logic [31:0] instruction = '0;

  logic       ready_out, op_valid, md_busy, illegal;
  logic [3:0] alu_op;
  logic       ready_nm, op_valid_nm, md_busy_nm, illegal_nm;
  logic [3:0] alu_op_nm;

  ula_control_mc #(
    .OP_W(4), .ENABLE_M(1'b1), .MUL_CYCLES(4), .DIV_CYCLES(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .alu_cmd(alu_cmd), .instruction(instruction), .alu_op(alu_op), .op_valid(op_valid),
    .op_ready(op_ready), .md_busy(md_busy), .illegal(illegal)
  );

  ula_control_mc #(
    .OP_W(4), .ENABLE_M(1'b0), .MUL_CYCLES(4), .DIV_CYCLES(32)
  ) dut_nm (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_nm), .ready_out(ready_nm),
    .alu_cmd(alu_cmd), .instruction(instruction), .alu_op(alu_op_nm),
    .op_valid(op_valid_nm), .op_ready(1'b1), .md_busy(md_busy_nm), .illegal(illegal_nm)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [3:0] op; logic ill;} exp_t;
  typedef struct packed {logic [3:0] cmd; logic [31:0] ins; logic [3:0] op; logic ill;} vec_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Consume side: every handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(op_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_op", 32'(alu_op), 32'(e.op));
        check("sb_illegal", 32'(illegal), 32'(e.ill));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] ins,
                       input logic [3:0] eop, input logic eill);
    bit ok = 1'b0;
    alu_cmd     = cmd;
    instruction = ins;
    valid_in    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back('{op: eop, ill: eill});
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic run_md(input logic [31:0] ins, input logic [3:0] eop, input int n);
    issue(4'h0, ins, eop, 1'b0);
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      if (i <= n) begin
        check("md_busy", 32'(md_busy), 32'd1);
        check("md_ready", 32'(ready_out), 32'd0);
        check("md_no_valid", 32'(op_valid), 32'd0);
        if (i == 1) check("md_op_early", 32'(alu_op), 32'(eop));
      end else begin
        check("md_busy_end", 32'(md_busy), 32'd0);
        check("md_valid_end", 32'(op_valid), 32'd1);
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{4'h0, 32'h00001033, 4'd5, 1'b0});
    tbl.push_back('{4'h0, 32'h00002033, 4'd8, 1'b0});
    tbl.push_back('{4'h0, 32'h00003033, 4'd9, 1'b0});
    tbl.push_back('{4'h0, 32'h00004033, 4'd4, 1'b0});
    tbl.push_back('{4'h0, 32'h00005033, 4'd6, 1'b0});
    tbl.push_back('{4'h0, 32'h40005033, 4'd7, 1'b0});
    tbl.push_back('{4'h0, 32'h00000033, 4'd0, 1'b0});
    tbl.push_back('{4'h0, 32'h40001033, 4'd15, 1'b1});
    tbl.push_back('{4'h0, 32'h10000033, 4'd15, 1'b1});
    tbl.push_back('{4'h0, 32'h02001033, 4'd11, 1'b0});
    tbl.push_back('{4'h1, 32'h40000033, 4'd0, 1'b0});
    tbl.push_back('{4'h2, 32'h00000033, 4'd1, 1'b0});
    tbl.push_back('{4'h3, 32'h00000033, 4'd2, 1'b0});
    tbl.push_back('{4'h7, 32'h40001033, 4'd0, 1'b0});
    tbl.push_back('{4'hF, 32'h02000033, 4'd0, 1'b0});
    tbl.push_back('{4'h4, 32'h40005013, 4'd7, 1'b0});
    tbl.push_back('{4'h4, 32'h00005013, 4'd6, 1'b0});
    tbl.push_back('{4'h4, 32'h40000013, 4'd0, 1'b0});
    tbl.push_back('{4'h4, 32'h00001013, 4'd5, 1'b0});
    tbl.push_back('{4'h4, 32'h00007013, 4'd2, 1'b0});
    tbl.push_back('{4'h0, 32'h02006033, 4'd13, 1'b0});
    tbl.push_back('{4'h0, 32'h00006033, 4'd3, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready_out), 32'd1);

    step();
    issue(4'h0, 32'h40000033, 4'd1, 1'b0);
    @(negedge clk);
    check("lat1_valid", 32'(op_valid), 32'd1);
    check("lat1_op", 32'(alu_op), 32'd1);
    check("lat1_illegal", 32'(illegal), 32'd0);
    step();
    issue(4'h0, 32'h00007033, 4'd2, 1'b0);
    issue(4'h0, 32'h00006033, 4'd3, 1'b0);
    step();
    step();

    pop_cyc.delete();
    issue(4'h1, 32'h0, 4'd0, 1'b0);
    issue(4'h2, 32'h0, 4'd1, 1'b0);
    issue(4'h3, 32'h0, 4'd2, 1'b0);
    step();
    step();
    check("b2b_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) check("b2b_span", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);

    run_md(32'h02000033, 4'd10, 4);
    run_md(32'h02004033, 4'd12, 32);

    op_ready = 1'b0;
    issue(4'h1, 32'h0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(op_valid), 32'd1);
      check("bp_op", 32'(alu_op), 32'd0);
      check("bp_ready", 32'(ready_out), 32'd0);
    end
    step();
    op_ready = 1'b1;
    issue(4'h0, 32'h00004033, 4'd4, 1'b0);
    @(negedge clk);
    check("bp_new_valid", 32'(op_valid), 32'd1);
    check("bp_new_op", 32'(alu_op), 32'd4);
    step();

    foreach (tbl[i]) issue(tbl[i].cmd, tbl[i].ins, tbl[i].op, tbl[i].ill);
    repeat (40) step();
    check("tbl_drain", 32'(exp_q.size()), 32'd0);

    alu_cmd     = 4'h0;
    instruction = 32'h02000033;
    valid_nm    = 1'b1;
    @(negedge clk);
    check("nm_ready", 32'(ready_nm), 32'd1);
    @(posedge clk);
    #1;
    valid_nm = 1'b0;
    @(negedge clk);
    check("nm_valid", 32'(op_valid_nm), 32'd1);
    check("nm_illegal", 32'(illegal_nm), 32'd1);
    check("nm_op", 32'(alu_op_nm), 32'd15);
    check("nm_md_busy", 32'(md_busy_nm), 32'd0);

    step();
    issue(4'h0, 32'h02004033, 4'd12, 1'b0);
    repeat (11) @(posedge clk);
    #3;
    check("pre_rst_busy", 32'(md_busy), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_md_busy", 32'(md_busy), 32'd0);
    check("arst_op_valid", 32'(op_valid), 32'd0);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", 32'(ready_out), 32'd1);
    check("arst_no_valid", 32'(op_valid), 32'd0);
    repeat (40) step();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
